horner_datapath: RTL and testbench
==================================

Name: horner_datapath

Overview:
Arithmetic responder for the polynomial-approximation controller. Evaluates acc = acc*x + c one Horner step at a time in signed fixed point. It latches the FIFO signal sample and the ROM coefficient, executes multiply and add on mul_valid_i/add_valid_i, and returns single-cycle mul_done_o/add_done_o pulses. The accumulated value is registered to the output on load_result_i.

Parameters:
DATA_W, 16, signed two's-complement width of signal, coefficient, accumulator and result
FRAC_W, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W); must be < DATA_W
MUL_LAT, 3, cycles from mul_valid_i to mul_done_o; >= 1
ADD_LAT, 1, cycles from add_valid_i to add_done_o; >= 1
RD_LAT, 1, read latency of FIFO/ROM data after rd_*_i (0 or 1)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
dp_reset_i  in  1  synchronous clear of the datapath, one-cycle pulse
rd_signal_i  in  1  FIFO read strobe issued by the controller
signal_i  in  DATA_W  FIFO read data (x)
rd_coeff_i  in  1  ROM read strobe issued by the controller
coeff_i  in  DATA_W  ROM read data (c)
mul_valid_i  in  1  start multiply: prod = acc*x
add_valid_i  in  1  start add: acc = prod + c
mul_done_o  out  1  one-cycle pulse, multiply complete
add_done_o  out  1  one-cycle pulse, add complete
load_result_i  in  1  copy acc to result_o
result_o  out  DATA_W  registered result
result_valid_o  out  1  one-cycle pulse, cycle after load_result_i
busy_o  out  1  multiply or add in flight
ovf_o  out  1  sticky, saturation occurred since the last dp_reset_i
err_o  out  1  sticky, protocol violation since the last dp_reset_i

Behaviour:
- Async reset: all registers 0. Outputs mul_done_o, add_done_o, result_o, result_valid_o, busy_o, ovf_o and err_o are all 0.
- Capture: x_reg <= signal_i, RD_LAT cycles after rd_signal_i (the edge ending that cycle). c_reg <= coeff_i, RD_LAT cycles after rd_coeff_i. Use delayed-strobe registers for this.
- States: IDLE, MUL, ADD. MUL and ADD each carry a down-counter.
- IDLE + mul_valid_i: sample acc and x_reg, load counter MUL_LAT, go to MUL.
  - Counter reaches completion: prod <= sat(trunc((acc*x) >>> FRAC_W)); mul_done_o=1 for exactly that cycle (cycle t+MUL_LAT when mul_valid_i is at t); return to IDLE.
  - prod is stable no later than the cycle mul_done_o is high.
- IDLE + add_valid_i: go to ADD with ADD_LAT counter.
  - On completion: acc <= sat(prod + c_reg), using c_reg as sampled at add_valid_i; add_done_o pulses at t+ADD_LAT; return to IDLE.
- Arithmetic:
  - Product is computed at 2*DATA_W with an arithmetic right shift by FRAC_W (truncate toward -inf).
  - Sum is computed at DATA_W+1.
  - Both saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; any clamp sets ovf_o.
- busy_o=1 in MUL and ADD.
- Protocol errors (each sets err_o):
  - mul_valid_i or add_valid_i while busy_o: request ignored, in-flight op unaffected.
  - mul_valid_i and add_valid_i in the same IDLE cycle: multiply taken, add dropped.
- dp_reset_i has highest priority:
  - Clears acc, prod, x_reg, c_reg, pending capture strobes, counters, ovf_o and err_o.
  - Aborts any in-flight op with no done pulse; state -> IDLE.
  - result_o is preserved.
- load_result_i: result_o <= acc at that edge; result_valid_o=1 the following cycle.
  - If coincident with add completion, result_o takes the pre-add acc.
  - If coincident with dp_reset_i, result_o takes the pre-clear acc.
- Back-to-back: a new mul_valid_i is accepted in the cycle after a done pulse, with no dead cycle required.
- First Horner step: acc=0 after dp_reset_i, so it yields acc=c_(n-1).
- Implementation: single clock, no combinational path from input to output; done/valid outputs are registered.

Test Plan:
- Polynomial, x=0x0200 (2.0), coeffs issued 0x0100, 0x0080, 0x0040 -> result_o=0x0540 (5.25). Each mul_done_o arrives exactly 3 cycles after mul_valid_i; ovf_o=0.
- Negative: x=0xFF00 (-1.0), coeffs 0x0100, 0x0100 -> acc 0x0100 then 0x0000; result_o=0x0000.
- Saturation: x=0x7F00, coeffs 0x7F00, 0x0000 -> prod clamps to 0x7FFF, ovf_o=1. A second run, coeffs 0x8100 (-127.0), 0x8000 with x=0x7F00, clamps to 0x8000.
- Mid-operation reset: dp_reset_i 1 cycle after mul_valid_i -> no mul_done_o, busy_o=0 next cycle, acc=0, result_o retains its prior value.
- Protocol error: mul_valid_i again during MUL -> err_o=1, single mul_done_o at original time. Simultaneous mul/add in IDLE -> multiply only, err_o=1.
- Read latency: with RD_LAT=1, signal_i changes the cycle after capture -> the captured value is used. load_result_i gives result_valid_o exactly one cycle later.

Source files
------------

// File: rtl/horner_datapath.sv
// horner_datapath
//   One Horner step of a polynomial approximation, acc = acc*x + c, executed
//   as two separately requested operations in signed Q(DATA_W-FRAC_W).FRAC_W:
//     multiply: prod <= sat((acc * x) >>> FRAC_W)   (MUL_LAT cycles)
//     add:      acc  <= sat(prod + c)               (ADD_LAT cycles)
//   x and c are captured from FIFO/ROM read data RD_LAT cycles after the
//   controller's read strobes. The accumulator is copied to result_o on
//   load_result_i.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   dp_reset_i           synchronous datapath clear (aborts in-flight op)
//   rd_signal_i/signal_i FIFO read strobe / read data (x)
//   rd_coeff_i/coeff_i   ROM read strobe / read data (c)
//   mul_valid_i          start multiply
//   add_valid_i          start add
//   mul_done_o           one-cycle pulse when the product is ready
//   add_done_o           one-cycle pulse when the accumulator is updated
//   load_result_i        copy acc to result_o
//   result_o             registered result
//   result_valid_o       one-cycle pulse the cycle after load_result_i
//   busy_o               multiply or add in flight
//   ovf_o                sticky saturation flag
//   err_o                sticky protocol-violation flag
module horner_datapath #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int MUL_LAT = 3,
  parameter int ADD_LAT = 1,
  parameter int RD_LAT  = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              dp_reset_i,
  input  logic              rd_signal_i,
  input  logic [DATA_W-1:0] signal_i,
  input  logic              rd_coeff_i,
  input  logic [DATA_W-1:0] coeff_i,
  input  logic              mul_valid_i,
  input  logic              add_valid_i,
  output logic              mul_done_o,
  output logic              add_done_o,
  input  logic              load_result_i,
  output logic [DATA_W-1:0] result_o,
  output logic              result_valid_o,
  output logic              busy_o,
  output logic              ovf_o,
  output logic              err_o
);

  localparam int MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic signed [2*DATA_W-1:0] SAT_MAX =
    {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] SAT_MIN =
    {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Clamp a wide signed value into DATA_W bits. MSB of the return value
  // flags that a clamp happened, the low DATA_W bits are the result.
  function automatic logic [DATA_W:0] sat_wide(input logic signed [2*DATA_W-1:0] v);
    logic [DATA_W:0] r;
    if (v > SAT_MAX)      r = {1'b1, SAT_MAX[DATA_W-1:0]};
    else if (v < SAT_MIN) r = {1'b1, SAT_MIN[DATA_W-1:0]};
    else                  r = {1'b0, v[DATA_W-1:0]};
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     mul_start, add_start, mul_cmpl, add_cmpl, proto_err;

  logic signed [DATA_W-1:0] acc_q, prod_q, x_q, c_q;
  logic                     rd_sig_p0, rd_coef_p0;
  logic                     sig_cap, coef_cap;

  // operands frozen at request time, so later captures cannot disturb an op
  logic signed [DATA_W-1:0] mul_a_p0, mul_b_p0, add_c_p0;

  logic signed [DATA_W-1:0] mul_a, mul_b, add_c;
  logic signed [2*DATA_W-1:0] mul_full, mul_shift;
  logic signed [DATA_W:0]   sum_w;
  logic [DATA_W:0]          mul_sat, add_sat;

  // ---------------------------------------------------------------------
  // FSM: state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state. A latency of 1 completes at the accepting edge, so the
  // op never occupies MUL/ADD and the block is back to IDLE for the next one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_start = 1'b0;
    add_start = 1'b0;
    mul_cmpl  = 1'b0;
    add_cmpl  = 1'b0;
    proto_err = 1'b0;
    if (dp_reset_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mul_valid_i) begin
            mul_start = 1'b1;
            proto_err = add_valid_i;
            if (MUL_LAT == 1) begin
              mul_cmpl = 1'b1;
            end else begin
              state_d = MUL;
              cnt_d   = CNT_W'(MUL_LAT - 1);
            end
          end else if (add_valid_i) begin
            add_start = 1'b1;
            if (ADD_LAT == 1) begin
              add_cmpl = 1'b1;
            end else begin
              state_d = ADD;
              cnt_d   = CNT_W'(ADD_LAT - 1);
            end
          end
        end
        MUL: begin
          proto_err = mul_valid_i | add_valid_i;
          if (cnt_q == CNT_W'(1)) begin
            mul_cmpl = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ADD: begin
          proto_err = mul_valid_i | add_valid_i;
          if (cnt_q == CNT_W'(1)) begin
            add_cmpl = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state_q != IDLE);
  end

  // ---------------------------------------------------------------------
  // Arithmetic (combinational from registered operands)
  assign sig_cap  = (RD_LAT == 0) ? rd_signal_i : rd_sig_p0;
  assign coef_cap = (RD_LAT == 0) ? rd_coeff_i  : rd_coef_p0;

  assign mul_a = (MUL_LAT == 1) ? acc_q : mul_a_p0;
  assign mul_b = (MUL_LAT == 1) ? x_q   : mul_b_p0;
  assign add_c = (ADD_LAT == 1) ? c_q   : add_c_p0;

  assign mul_full  = $signed({{DATA_W{mul_a[DATA_W-1]}}, mul_a}) *
                     $signed({{DATA_W{mul_b[DATA_W-1]}}, mul_b});
  assign mul_shift = mul_full >>> FRAC_W;
  assign mul_sat   = sat_wide(mul_shift);

  assign sum_w   = $signed({prod_q[DATA_W-1], prod_q}) + $signed({add_c[DATA_W-1], add_c});
  assign add_sat = sat_wide($signed({{(DATA_W-1){sum_w[DATA_W]}}, sum_w}));

  // ---------------------------------------------------------------------
  // p0: capture / operand sampling; result stage: prod, acc, flags
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_sig_p0      <= 1'b0;
      rd_coef_p0     <= 1'b0;
      x_q            <= '0;
      c_q            <= '0;
      mul_a_p0       <= '0;
      mul_b_p0       <= '0;
      add_c_p0       <= '0;
      prod_q         <= '0;
      acc_q          <= '0;
      mul_done_o     <= 1'b0;
      add_done_o     <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      ovf_o          <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      mul_done_o     <= mul_cmpl;
      add_done_o     <= add_cmpl;
      result_valid_o <= load_result_i;
      // samples acc before any same-edge add or clear
      if (load_result_i) result_o <= acc_q;

      if (dp_reset_i) begin
        rd_sig_p0  <= 1'b0;
        rd_coef_p0 <= 1'b0;
        x_q        <= '0;
        c_q        <= '0;
        mul_a_p0   <= '0;
        mul_b_p0   <= '0;
        add_c_p0   <= '0;
        prod_q     <= '0;
        acc_q      <= '0;
        ovf_o      <= 1'b0;
        err_o      <= 1'b0;
      end else begin
        rd_sig_p0  <= rd_signal_i;
        rd_coef_p0 <= rd_coeff_i;
        if (sig_cap)  x_q <= signal_i;
        if (coef_cap) c_q <= coeff_i;
        if (mul_start) begin
          mul_a_p0 <= acc_q;
          mul_b_p0 <= x_q;
        end
        if (add_start) add_c_p0 <= c_q;
        if (mul_cmpl) begin
          prod_q <= mul_sat[DATA_W-1:0];
          if (mul_sat[DATA_W]) ovf_o <= 1'b1;
        end
        if (add_cmpl) begin
          acc_q <= add_sat[DATA_W-1:0];
          if (add_sat[DATA_W]) ovf_o <= 1'b1;
        end
        if (proto_err) err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_horner_datapath.sv
// tb_horner_datapath
//   Directed bench for horner_datapath with default parameters
//   (DATA_W=16, FRAC_W=8, MUL_LAT=3, ADD_LAT=1, RD_LAT=1).
module tb_horner_datapath;

  localparam int DATA_W = 16;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              dp_reset_i = 1'b0;
  logic              rd_signal_i = 1'b0;
  logic [DATA_W-1:0] signal_i = '0;
  logic              rd_coeff_i = 1'b0;
  logic [DATA_W-1:0] coeff_i = '0;
  logic              mul_valid_i = 1'b0;
  logic              add_valid_i = 1'b0;
  logic              load_result_i = 1'b0;
  logic              mul_done_o, add_done_o, result_valid_o, busy_o, ovf_o, err_o;
  logic [DATA_W-1:0] result_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  horner_datapath #(
    .DATA_W (16),
    .FRAC_W (8),
    .MUL_LAT(3),
    .ADD_LAT(1),
    .RD_LAT (1)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .dp_reset_i    (dp_reset_i),
    .rd_signal_i   (rd_signal_i),
    .signal_i      (signal_i),
    .rd_coeff_i    (rd_coeff_i),
    .coeff_i       (coeff_i),
    .mul_valid_i   (mul_valid_i),
    .add_valid_i   (add_valid_i),
    .mul_done_o    (mul_done_o),
    .add_done_o    (add_done_o),
    .load_result_i (load_result_i),
    .result_o      (result_o),
    .result_valid_o(result_valid_o),
    .busy_o        (busy_o),
    .ovf_o         (ovf_o),
    .err_o         (err_o)
  );

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_dp_reset();
    dp_reset_i = 1'b1;
    step();
    dp_reset_i = 1'b0;
  endtask

  // strobe, then data one cycle later, then data changes immediately after
  task automatic load_x(input logic [DATA_W-1:0] v);
    rd_signal_i = 1'b1;
    signal_i    = 16'hDEAD;
    step();
    rd_signal_i = 1'b0;
    signal_i    = v;
    step();
    signal_i    = ~v;
  endtask

  task automatic load_c(input logic [DATA_W-1:0] v);
    rd_coeff_i = 1'b1;
    coeff_i    = 16'hBEEF;
    step();
    rd_coeff_i = 1'b0;
    coeff_i    = v;
    step();
    coeff_i    = ~v;
  endtask

  // returns cycles from request to done (20 means it never came)
  task automatic do_mul(output int lat);
    mul_valid_i = 1'b1;
    step();
    mul_valid_i = 1'b0;
    lat = 1;
    while (mul_done_o !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    step();
  endtask

  task automatic do_add(output int lat);
    add_valid_i = 1'b1;
    step();
    add_valid_i = 1'b0;
    lat = 1;
    while (add_done_o !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    step();
  endtask

  task automatic horner_step(input logic [DATA_W-1:0] c, output int ml, output int al);
    load_c(c);
    do_mul(ml);
    do_add(al);
  endtask

  task automatic read_result(output logic [DATA_W-1:0] r, output logic v_at, output logic v_after);
    load_result_i = 1'b1;
    step();
    load_result_i = 1'b0;
    v_at = result_valid_o;
    r    = result_o;
    step();
    v_after = result_valid_o;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (mul_done_o !== 1'b0) begin errors++; $display("FAIL reset_mul_done got %b exp 0", mul_done_o); end
    checks++; if (add_done_o !== 1'b0) begin errors++; $display("FAIL reset_add_done got %b exp 0", add_done_o); end
    checks++; if (result_o !== 16'h0000) begin errors++; $display("FAIL reset_result got %h exp 0000", result_o); end
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_result_valid got %b exp 0", result_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
    #10 rstn_i = 1'b1;
    step();
  endtask

  task automatic test_polynomial();
    logic [DATA_W-1:0] coefs [3];
    logic [DATA_W-1:0] r;
    logic va, vn;
    int ml, al;
    coefs[0] = 16'h0100; coefs[1] = 16'h0080; coefs[2] = 16'h0040;
    pulse_dp_reset();
    load_x(16'h0200);
    for (int i = 0; i < 3; i++) begin
      horner_step(coefs[i], ml, al);
      checks++; if (ml != 3) begin errors++; $display("FAIL poly_mul_lat step %0d got %0d exp 3", i, ml); end
      checks++; if (al != 1) begin errors++; $display("FAIL poly_add_lat step %0d got %0d exp 1", i, al); end
    end
    read_result(r, va, vn);
    checks++; if (r !== 16'h0540) begin errors++; $display("FAIL poly_result got %h exp 0540", r); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL poly_ovf got %b exp 0", ovf_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL poly_err got %b exp 0", err_o); end
  endtask

  task automatic test_negative();
    logic [DATA_W-1:0] r;
    logic va, vn;
    int ml, al;
    pulse_dp_reset();
    load_x(16'hFF00);
    horner_step(16'h0100, ml, al);
    read_result(r, va, vn);
    checks++; if (r !== 16'h0100) begin errors++; $display("FAIL neg_acc1 got %h exp 0100", r); end
    horner_step(16'h0100, ml, al);
    read_result(r, va, vn);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL neg_result got %h exp 0000", r); end
    // 1/256 * -0.5 = -1/512, truncation toward -inf gives -1 LSB
    pulse_dp_reset();
    load_x(16'hFF80);
    horner_step(16'h0001, ml, al);
    horner_step(16'h0000, ml, al);
    read_result(r, va, vn);
    checks++; if (r !== 16'hFFFF) begin errors++; $display("FAIL neg_trunc got %h exp ffff", r); end
  endtask

  task automatic test_saturation();
    logic [DATA_W-1:0] r;
    logic va, vn;
    int ml, al;
    pulse_dp_reset();
    load_x(16'h7F00);
    horner_step(16'h7F00, ml, al);
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL sat_pos_ovf_early got %b exp 0", ovf_o); end
    horner_step(16'h0000, ml, al);
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf got %b exp 1", ovf_o); end
    read_result(r, va, vn);
    checks++; if (r !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_result got %h exp 7fff", r); end
    pulse_dp_reset();
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL sat_ovf_cleared got %b exp 0", ovf_o); end
    load_x(16'h7F00);
    horner_step(16'h8100, ml, al);
    horner_step(16'h8000, ml, al);
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL sat_neg_ovf got %b exp 1", ovf_o); end
    read_result(r, va, vn);
    checks++; if (r !== 16'h8000) begin errors++; $display("FAIL sat_neg_result got %h exp 8000", r); end
  endtask

  task automatic test_mid_reset();
    logic [DATA_W-1:0] r;
    logic va, vn;
    int ml, al;
    int seen;
    pulse_dp_reset();
    load_x(16'h0200);
    horner_step(16'h0100, ml, al);
    read_result(r, va, vn);
    checks++; if (r !== 16'h0100) begin errors++; $display("FAIL midrst_pre_result got %h exp 0100", r); end
    mul_valid_i = 1'b1;
    step();
    mul_valid_i = 1'b0;
    dp_reset_i  = 1'b1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", busy_o); end
    step();
    dp_reset_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy_after got %b exp 0", busy_o); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (mul_done_o === 1'b1) seen++;
      step();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses exp 0", seen); end
    checks++; if (result_o !== 16'h0100) begin errors++; $display("FAIL midrst_result_kept got %h exp 0100", result_o); end
    read_result(r, va, vn);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL midrst_acc_cleared got %h exp 0000", r); end
  endtask

  task automatic test_protocol_error();
    int seen_mul, seen_add;
    pulse_dp_reset();
    load_x(16'h0100);
    // second mul request while MUL is in flight
    mul_valid_i = 1'b1;
    step();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL perr_err_early got %b exp 0", err_o); end
    step();
    mul_valid_i = 1'b0;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL perr_err_busy got %b exp 1", err_o); end
    checks++; if (mul_done_o !== 1'b0) begin errors++; $display("FAIL perr_done_early got %b exp 0", mul_done_o); end
    step();
    checks++; if (mul_done_o !== 1'b1) begin errors++; $display("FAIL perr_done_time got %b exp 1", mul_done_o); end
    seen_mul = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mul_done_o === 1'b1) seen_mul++;
    end
    checks++; if (seen_mul != 0) begin errors++; $display("FAIL perr_extra_done got %0d exp 0", seen_mul); end
    // simultaneous mul and add from IDLE
    pulse_dp_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL perr_err_cleared got %b exp 0", err_o); end
    mul_valid_i = 1'b1;
    add_valid_i = 1'b1;
    step();
    mul_valid_i = 1'b0;
    add_valid_i = 1'b0;
    seen_mul = 0;
    seen_add = 0;
    for (int i = 0; i < 6; i++) begin
      if (mul_done_o === 1'b1) seen_mul++;
      if (add_done_o === 1'b1) seen_add++;
      step();
    end
    checks++; if (seen_mul != 1) begin errors++; $display("FAIL perr_sim_mul got %0d exp 1", seen_mul); end
    checks++; if (seen_add != 0) begin errors++; $display("FAIL perr_sim_add got %0d exp 0", seen_add); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL perr_sim_err got %b exp 1", err_o); end
  endtask

  task automatic test_back_to_back();
    int ml1, ml2, al;
    pulse_dp_reset();
    load_x(16'h0200);
    do_mul(ml1);
    do_mul(ml2);
    do_add(al);
    checks++; if (ml1 != 3) begin errors++; $display("FAIL b2b_mul1_lat got %0d exp 3", ml1); end
    checks++; if (ml2 != 3) begin errors++; $display("FAIL b2b_mul2_lat got %0d exp 3", ml2); end
    checks++; if (al != 1) begin errors++; $display("FAIL b2b_add_lat got %0d exp 1", al); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", err_o); end
  endtask

  task automatic test_read_latency();
    logic [DATA_W-1:0] r;
    logic va, vn;
    int ml, al;
    pulse_dp_reset();
    load_x(16'h0200);
    horner_step(16'h0100, ml, al);
    horner_step(16'h0000, ml, al);
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rdlat_valid_idle got %b exp 0", result_valid_o); end
    read_result(r, va, vn);
    checks++; if (r !== 16'h0200) begin errors++; $display("FAIL rdlat_result got %h exp 0200", r); end
    checks++; if (va !== 1'b1) begin errors++; $display("FAIL rdlat_valid_pulse got %b exp 1", va); end
    checks++; if (vn !== 1'b0) begin errors++; $display("FAIL rdlat_valid_end got %b exp 0", vn); end
  endtask

  initial begin
    test_reset();
    test_polynomial();
    test_negative();
    test_saturation();
    test_mid_reset();
    test_protocol_error();
    test_back_to_back();
    test_read_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
